// File: rtl/tsqr_st512_1c.sv
// tsqr_st512_1c: double-buffered tile loader feeding a triangular accumulator RAM.
// Build option SINGLE_CORE_INT_EN exposes mem0_fi_c_0/mem1_fi_c_0 as ports.
module tsqr_st512_1c #(
    parameter int MATRIX_WIDTH   = 256,
    parameter int RAM_WIDTH      = MATRIX_WIDTH * 64,
    parameter int RAM_ADDR_WIDTH = 8,
    parameter int CNT_WIDTH      = 16,
    parameter int MEM_NO         = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CNT_WIDTH-1:0]      tile_no,
    input  logic [RAM_WIDTH-1:0]      ug_i,
    input  logic [RAM_WIDTH-1:0]      pg_i,
    input  logic                      ug_ready,
    input  logic                      pg_ready,
    input  logic [31:0]               e_ug,
    input  logic [31:0]               e_pg,
    input  logic [31:0]               e_upg,
    input  logic                      e_ug_ready,
    input  logic                      e_pg_ready,
    input  logic                      e_upg_ready,
    input  logic [MEM_NO-1:0]         dma_mem_enb,
    input  logic [RAM_ADDR_WIDTH-1:0] dma_mem_addrb,
    output logic [RAM_WIDTH-1:0]      dma_mem_doutb,
`ifdef SINGLE_CORE_INT_EN
    output logic                      mem0_fi_c_0,
    output logic                      mem1_fi_c_0,
`endif
    output logic                      tsqr_fi
);
    typedef enum logic [1:0] {IDLE, PROC, FIN} state_t;

    localparam logic [RAM_ADDR_WIDTH-1:0] ROW_LAST = RAM_ADDR_WIDTH'(MATRIX_WIDTH - 1);
    localparam logic [RAM_ADDR_WIDTH-1:0] ROW_ONE  = RAM_ADDR_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]      CNT_ONE  = CNT_WIDTH'(1);

`ifndef SINGLE_CORE_INT_EN
    logic mem0_fi_c_0;
    logic mem1_fi_c_0;
`endif

    logic [2*RAM_WIDTH-1:0] mem0    [MATRIX_WIDTH];
    logic [2*RAM_WIDTH-1:0] mem1    [MATRIX_WIDTH];
    logic [RAM_WIDTH-1:0]   tri_mem [MATRIX_WIDTH];
    logic [95:0]            sc_ram  [MATRIX_WIDTH];

    state_t                    state_q, state_d;
    logic [RAM_ADDR_WIDTH-1:0] wr_row_q, wr_row_d;
    logic [RAM_ADDR_WIDTH-1:0] e_row_q, e_row_d;
    logic [RAM_ADDR_WIDTH-1:0] rd_row_q, rd_row_d;
    logic [RAM_ADDR_WIDTH-1:0] p_row_q, p_row_d;
    logic [CNT_WIDTH-1:0]      tile_cnt_q, tile_cnt_d;
    logic [CNT_WIDTH-1:0]      tn_q, tn_d;
    logic                      wr_buf_q, wr_buf_d;
    logic                      tn_vld_q, tn_vld_d;
    logic                      ld_q, ld_d;
    logic                      ld_buf_q, ld_buf_d;
    logic                      rd_act_q, rd_act_d;
    logic                      proc_buf_q, proc_buf_d;
    logic                      p_vld_q, p_vld_d;
    logic                      mem0_fi_q, mem0_fi_d;
    logic                      mem1_fi_q, mem1_fi_d;
    logic                      tsqr_fi_q, tsqr_fi_d;
    logic [RAM_WIDTH-1:0]      dout_q, dout_d;

    logic [2*RAM_WIDTH-1:0]    p_src_q;
    logic [RAM_WIDTH-1:0]      p_tri_q;
    logic [RAM_WIDTH-1:0]      tri_new;
    logic [CNT_WIDTH-1:0]      tile_lim;
    logic                      accept, wrap, e_wr, last_wr, first;

    assign accept   = ug_ready & pg_ready;
    assign wrap     = accept && (wr_row_q == ROW_LAST);
    assign e_wr     = e_ug_ready & e_pg_ready & e_upg_ready;
    assign last_wr  = p_vld_q && (p_row_q == ROW_LAST);
    assign first    = (tile_cnt_q == '0);
    assign tile_lim = (tn_q == '0) ? CNT_ONE : tn_q;

    assign dma_mem_doutb = dout_q;
    assign mem0_fi_c_0   = mem0_fi_q;
    assign mem1_fi_c_0   = mem1_fi_q;
    assign tsqr_fi       = tsqr_fi_q;

    always_comb begin
        tri_new = '0;
        for (int c = 0; c < MATRIX_WIDTH; c++) begin
            if (c >= int'(p_row_q))
                tri_new[64*c +: 64] = (first ? 64'd0 : p_tri_q[64*c +: 64])
                                    + p_src_q[RAM_WIDTH + 64*c +: 64]
                                    + p_src_q[64*c +: 64];
        end
    end

    // Buffer rows hold {ug,pg}; the DMA port returns the pg half.
    always_comb begin
        dout_d = dout_q;
        if (dma_mem_enb[0])
            dout_d = mem0[dma_mem_addrb][RAM_WIDTH-1:0];
        else if (dma_mem_enb[1])
            dout_d = mem1[dma_mem_addrb][RAM_WIDTH-1:0];
        else if (dma_mem_enb[2])
            dout_d = tri_mem[dma_mem_addrb];
        else if (dma_mem_enb[3])
            dout_d = RAM_WIDTH'(sc_ram[dma_mem_addrb]);
    end

    always_comb begin
        state_d    = state_q;
        wr_row_d   = wr_row_q;
        e_row_d    = e_row_q;
        wr_buf_d   = wr_buf_q;
        tile_cnt_d = tile_cnt_q;
        tn_d       = tn_q;
        tn_vld_d   = tn_vld_q;
        ld_d       = ld_q;
        ld_buf_d   = ld_buf_q;
        rd_act_d   = rd_act_q;
        rd_row_d   = rd_row_q;
        proc_buf_d = proc_buf_q;
        p_vld_d    = rd_act_q;
        p_row_d    = rd_row_q;
        mem0_fi_d  = 1'b0;
        mem1_fi_d  = 1'b0;
        tsqr_fi_d  = 1'b0;
        if (accept) begin
            wr_row_d = wrap ? '0 : wr_row_q + ROW_ONE;
            if (!tn_vld_q) begin
                tn_d     = tile_no;
                tn_vld_d = 1'b1;
            end
            if (wrap) begin
                wr_buf_d = ~wr_buf_q;
                ld_d     = 1'b1;
                ld_buf_d = wr_buf_q;
            end
        end
        if (e_wr)
            e_row_d = (e_row_q == ROW_LAST) ? '0 : e_row_q + ROW_ONE;
        if (rd_act_q) begin
            rd_row_d = (rd_row_q == ROW_LAST) ? '0 : rd_row_q + ROW_ONE;
            rd_act_d = (rd_row_q != ROW_LAST);
        end
        unique case (state_q)
            IDLE: begin
                if (ld_q) begin
                    state_d    = PROC;
                    rd_act_d   = 1'b1;
                    rd_row_d   = '0;
                    proc_buf_d = ld_buf_q;
                    ld_d       = wrap;
                end
            end
            PROC: begin
                if (last_wr) begin
                    mem0_fi_d  = ~proc_buf_q;
                    mem1_fi_d  = proc_buf_q;
                    tile_cnt_d = tile_cnt_q + CNT_ONE;
                    // A load finishing this very cycle counts as pending.
                    if (ld_q || wrap) begin
                        rd_act_d   = 1'b1;
                        rd_row_d   = '0;
                        proc_buf_d = ld_q ? ld_buf_q : wr_buf_q;
                        ld_d       = ld_q && wrap;
                    end else if (tile_cnt_q + CNT_ONE == tile_lim) begin
                        state_d = FIN;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            FIN: begin
                tsqr_fi_d  = mem0_fi_c_0 | mem1_fi_c_0;
                state_d    = IDLE;
                wr_row_d   = '0;
                e_row_d    = '0;
                wr_buf_d   = 1'b0;
                tile_cnt_d = '0;
                tn_d       = '0;
                tn_vld_d   = 1'b0;
                ld_d       = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            wr_row_q   <= '0;
            e_row_q    <= '0;
            rd_row_q   <= '0;
            p_row_q    <= '0;
            tile_cnt_q <= '0;
            tn_q       <= '0;
            wr_buf_q   <= 1'b0;
            tn_vld_q   <= 1'b0;
            ld_q       <= 1'b0;
            ld_buf_q   <= 1'b0;
            rd_act_q   <= 1'b0;
            proc_buf_q <= 1'b0;
            p_vld_q    <= 1'b0;
            mem0_fi_q  <= 1'b0;
            mem1_fi_q  <= 1'b0;
            tsqr_fi_q  <= 1'b0;
            dout_q     <= '0;
        end else begin
            state_q    <= state_d;
            wr_row_q   <= wr_row_d;
            e_row_q    <= e_row_d;
            rd_row_q   <= rd_row_d;
            p_row_q    <= p_row_d;
            tile_cnt_q <= tile_cnt_d;
            tn_q       <= tn_d;
            wr_buf_q   <= wr_buf_d;
            tn_vld_q   <= tn_vld_d;
            ld_q       <= ld_d;
            ld_buf_q   <= ld_buf_d;
            rd_act_q   <= rd_act_d;
            proc_buf_q <= proc_buf_d;
            p_vld_q    <= p_vld_d;
            mem0_fi_q  <= mem0_fi_d;
            mem1_fi_q  <= mem1_fi_d;
            tsqr_fi_q  <= tsqr_fi_d;
            dout_q     <= dout_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            if (wr_buf_q)
                mem1[wr_row_q] <= {ug_i, pg_i};
            else
                mem0[wr_row_q] <= {ug_i, pg_i};
        end
        if (e_wr)
            sc_ram[e_row_q] <= {e_upg, e_pg, e_ug};
        if (rd_act_q) begin
            p_src_q <= proc_buf_q ? mem1[rd_row_q] : mem0[rd_row_q];
            p_tri_q <= tri_mem[rd_row_q];
        end
        if (p_vld_q)
            tri_mem[p_row_q] <= tri_new;
    end
endmodule

// File: tb/tb_tsqr_st512_1c.sv
// tb_tsqr_st512_1c: directed + randomized bench for tsqr_st512_1c at MATRIX_WIDTH=4.
// Reference model keeps tile sums per row/lane with plain 64-bit arithmetic.
module tb_tsqr_st512_1c;
    localparam int MW = 4;
    localparam int RW = MW * 64;
    localparam int AW = 2;
    localparam int CW = 16;
    localparam int MN = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [CW-1:0] tile_no;
    logic [RW-1:0] ug_i, pg_i;
    logic          ug_ready, pg_ready;
    logic [31:0]   e_ug, e_pg, e_upg;
    logic          e_ug_ready, e_pg_ready, e_upg_ready;
    logic [MN-1:0] dma_mem_enb;
    logic [AW-1:0] dma_mem_addrb;
    logic [RW-1:0] dma_mem_doutb;
    logic          m0fi, m1fi, tsqr_fi;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ev_k[$];
    int ev_c[$];

    logic [RW-1:0] tu [MW];
    logic [RW-1:0] tp [MW];
    logic [RW-1:0] tri_m [MW];
    logic [RW-1:0] pg_m [2][MW];
    int tile_idx = 0;
    int bufsel = 0;

    tsqr_st512_1c #(
        .MATRIX_WIDTH(MW), .RAM_WIDTH(RW), .RAM_ADDR_WIDTH(AW),
        .CNT_WIDTH(CW), .MEM_NO(MN)
    ) dut (
        .clk(clk), .rst(rst), .tile_no(tile_no),
        .ug_i(ug_i), .pg_i(pg_i),
        .ug_ready(ug_ready), .pg_ready(pg_ready),
        .e_ug(e_ug), .e_pg(e_pg), .e_upg(e_upg),
        .e_ug_ready(e_ug_ready), .e_pg_ready(e_pg_ready),
        .e_upg_ready(e_upg_ready),
        .dma_mem_enb(dma_mem_enb), .dma_mem_addrb(dma_mem_addrb),
        .dma_mem_doutb(dma_mem_doutb),
`ifdef SINGLE_CORE_INT_EN
        .mem0_fi_c_0(m0fi), .mem1_fi_c_0(m1fi),
`endif
        .tsqr_fi(tsqr_fi)
    );

`ifndef SINGLE_CORE_INT_EN
    assign m0fi = dut.mem0_fi_c_0;
    assign m1fi = dut.mem1_fi_c_0;
`endif

    // Event log: 0 = mem0 done, 1 = mem1 done, 2 = job done.
    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (m0fi === 1'b1) begin ev_k.push_back(0); ev_c.push_back(cyc); end
        if (m1fi === 1'b1) begin ev_k.push_back(1); ev_c.push_back(cyc); end
        if (tsqr_fi === 1'b1) begin ev_k.push_back(2); ev_c.push_back(cyc); end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic int evk(input int i);
        return (i < ev_k.size()) ? ev_k[i] : -1;
    endfunction

    function automatic int evc(input int i);
        return (i < ev_c.size()) ? ev_c[i] : -1;
    endfunction

    task automatic check(input string tag, input logic [RW-1:0] obs,
                         input logic [RW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_ev();
        ev_k.delete();
        ev_c.delete();
    endtask

    task automatic fill_const(input logic [63:0] u, input logic [63:0] p);
        for (int r = 0; r < MW; r++)
            for (int c = 0; c < MW; c++) begin
                tu[r][64*c +: 64] = u;
                tp[r][64*c +: 64] = p;
            end
    endtask

    task automatic fill_rand();
        for (int r = 0; r < MW; r++)
            for (int c = 0; c < MW; c++) begin
                tu[r][64*c +: 64] = {$urandom(), $urandom()};
                tp[r][64*c +: 64] = {$urandom(), $urandom()};
            end
    endtask

    task automatic push_tile();
        logic [63:0] prev;
        for (int r = 0; r < MW; r++) begin
            @(negedge clk);
            ug_i = tu[r];
            pg_i = tp[r];
            ug_ready = 1'b1;
            pg_ready = 1'b1;
            pg_m[bufsel][r] = tp[r];
        end
        for (int r = 0; r < MW; r++)
            for (int c = 0; c < MW; c++) begin
                prev = (tile_idx == 0) ? 64'd0 : tri_m[r][64*c +: 64];
                if (c >= r)
                    tri_m[r][64*c +: 64] = prev + tu[r][64*c +: 64] + tp[r][64*c +: 64];
                else
                    tri_m[r][64*c +: 64] = 64'd0;
            end
        tile_idx++;
        bufsel ^= 1;
    endtask

    task automatic idle_rows();
        @(negedge clk);
        ug_ready = 1'b0;
        pg_ready = 1'b0;
        ug_i = '0;
        pg_i = '0;
    endtask

    task automatic end_job();
        tile_idx = 0;
        bufsel = 0;
    endtask

    task automatic wait_ev(input int n, input string tag);
        int k;
        k = 0;
        while (ev_k.size() < n && k < 200) begin
            @(negedge clk);
            k++;
        end
        check(tag, ev_k.size(), n);
    endtask

    task automatic dma_rd(input logic [MN-1:0] enb, input int addr,
                          output logic [RW-1:0] d);
        @(negedge clk);
        dma_mem_enb = enb;
        dma_mem_addrb = addr[AW-1:0];
        @(negedge clk);
        d = dma_mem_doutb;
        dma_mem_enb = '0;
    endtask

    task automatic chk_tri(input string tag);
        logic [RW-1:0] d;
        for (int r = 0; r < MW; r++) begin
            dma_rd(4'b0100, r, d);
            check($sformatf("%s_tri%0d", tag, r), d, tri_m[r]);
        end
    endtask

    initial begin
        logic [RW-1:0] d, hold, sc_exp, sc_rnd;
        logic [31:0] ru, rp, rq;

        rst = 1'b0;
        tile_no = '0;
        ug_i = '0; pg_i = '0; ug_ready = 1'b0; pg_ready = 1'b0;
        e_ug = '0; e_pg = '0; e_upg = '0;
        e_ug_ready = 1'b0; e_pg_ready = 1'b0; e_upg_ready = 1'b0;
        dma_mem_enb = '0; dma_mem_addrb = '0;
        repeat (3) @(negedge clk);
        check("rst_dout", dma_mem_doutb, '0);
        check("rst_tsqr_fi", tsqr_fi, '0);
        check("rst_mem0_fi", m0fi, '0);
        check("rst_mem1_fi", m1fi, '0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single tile, ug=1 pg=2.
        clr_ev();
        tile_no = 1;
        fill_const(64'd1, 64'd2);
        push_tile();
        idle_rows();
        wait_ev(2, "s1_nev");
        check("s1_ev0", evk(0), 0);
        check("s1_ev1", evk(1), 2);
        check("s1_fi_gap", evc(1) - evc(0), 1);
        end_job();
        repeat (3) @(negedge clk);
        chk_tri("s1");
        check("s1_lane_const", tri_m[1][127:64], 64'd3);

        // Four tiles: three back-to-back, fourth after mem0 done.
        clr_ev();
        tile_no = 4;
        fill_const(64'd1, 64'd1);
        push_tile();
        push_tile();
        push_tile();
        idle_rows();
        wait_ev(3, "s2_nev3");
        check("s2_ev0", evk(0), 0);
        check("s2_ev1", evk(1), 1);
        check("s2_ev2", evk(2), 0);
        push_tile();
        idle_rows();
        wait_ev(5, "s2_nev5");
        check("s2_ev3", evk(3), 1);
        check("s2_ev4", evk(4), 2);
        check("s2_fi_gap", evc(4) - evc(3), 1);
        end_job();
        repeat (3) @(negedge clk);
        chk_tri("s2");
        check("s2_lane_const", tri_m[0][63:0], 64'd8);

        // Half-handshakes must be ignored; then a random two-tile job.
        clr_ev();
        tile_no = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ug_i = {8{$urandom()}}; pg_i = {8{$urandom()}};
            ug_ready = 1'b1; pg_ready = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ug_i = {8{$urandom()}}; pg_i = {8{$urandom()}};
            ug_ready = 1'b0; pg_ready = 1'b1;
        end
        idle_rows();
        repeat (12) @(negedge clk);
        check("s3_ignored_nev", ev_k.size(), 0);
        tile_no = 2;
        fill_rand();
        push_tile();
        fill_rand();
        push_tile();
        idle_rows();
        wait_ev(3, "s3_nev");
        check("s3_ev0", evk(0), 0);
        check("s3_ev1", evk(1), 1);
        check("s3_ev2", evk(2), 2);
        end_job();
        repeat (3) @(negedge clk);
        chk_tri("s3");

        // Scalar RAM capture, partial readies write nothing.
        ru = $urandom(); rp = $urandom(); rq = $urandom();
        @(negedge clk);
        e_ug = 32'h40400000; e_pg = 32'h40800000; e_upg = 32'h40000000;
        e_ug_ready = 1'b1; e_pg_ready = 1'b1; e_upg_ready = 1'b1;
        @(negedge clk);
        e_ug = ~ru; e_pg = ~rp; e_upg = ~rq;
        e_upg_ready = 1'b0;
        @(negedge clk);
        e_ug = ru; e_pg = rp; e_upg = rq;
        e_upg_ready = 1'b1;
        @(negedge clk);
        e_ug_ready = 1'b0; e_pg_ready = 1'b0; e_upg_ready = 1'b0;
        sc_exp = '0;
        sc_exp[95:0] = {32'h40000000, 32'h40800000, 32'h40400000};
        sc_rnd = '0;
        sc_rnd[95:0] = {rq, rp, ru};
        dma_rd(4'b1000, 0, d);
        check("s4_sc0", d, sc_exp);
        dma_rd(4'b1000, 1, d);
        check("s4_sc1", d, sc_rnd);
        hold = d;
        repeat (3) @(negedge clk);
        check("s4_hold", dma_mem_doutb, hold);

        // Multi-bit selects: lowest set bit wins.
        for (int r = 0; r < MW; r++) begin
            dma_rd(4'b0110, r, d);
            check($sformatf("s4_prio_mem1_r%0d", r), d, pg_m[1][r]);
        end
        dma_rd(4'b0011, 2, d);
        check("s4_prio_mem0", d, pg_m[0][2]);
        dma_rd(4'b1100, 3, d);
        check("s4_prio_tri", d, tri_m[3]);

        // Reset in the middle of processing.
        clr_ev();
        tile_no = 1;
        fill_rand();
        push_tile();
        idle_rows();
        dma_rd(4'b1000, 0, d);
        check("s5_pre_dout", d, sc_exp);
        #2;
        rst = 1'b0;
        #1;
        check("s5_rst_dout", dma_mem_doutb, '0);
        check("s5_rst_tsqr_fi", tsqr_fi, '0);
        check("s5_rst_mem0_fi", m0fi, '0);
        check("s5_rst_mem1_fi", m1fi, '0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        end_job();
        repeat (12) @(negedge clk);
        check("s5_abort_nev", ev_k.size(), 0);
        fill_rand();
        push_tile();
        idle_rows();
        wait_ev(2, "s5_nev");
        check("s5_ev0", evk(0), 0);
        check("s5_ev1", evk(1), 2);
        end_job();
        repeat (3) @(negedge clk);
        chk_tri("s5");

        // tile_no=0 behaves as a single-tile job.
        clr_ev();
        tile_no = 0;
        fill_rand();
        push_tile();
        idle_rows();
        wait_ev(2, "s6_nev");
        check("s6_ev0", evk(0), 0);
        check("s6_ev1", evk(1), 2);
        end_job();
        repeat (3) @(negedge clk);
        chk_tri("s6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
